// File: rtl/snake_game_ctrl_pkg.sv
// Shared encodings and constants for the snake game controller.
package snake_game_ctrl_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPlace = 2'd2,
    StOver  = 2'd3
  } state_e;

  localparam int unsigned FieldSize  = 16;
  localparam logic [3:0]  FieldMax   = 4'(FieldSize - 1);
  localparam logic [3:0]  InitHeadX  = 4'd8;
  localparam logic [3:0]  InitHeadY  = 4'd8;
  localparam logic [3:0]  InitAppleX = 4'd12;
  localparam logic [3:0]  InitAppleY = 4'd8;
  localparam logic [7:0]  LfsrSeed   = 8'hA5;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic logic is_reverse(input dir_e a, input dir_e b);
    return (a ^ b) == 2'd2;
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used for apple placement.
module snake_lfsr
  import snake_game_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] value_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game state: body shift register, apple, score and phase; answers cell occupancy queries.
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned START_LEN = 3,
  parameter int unsigned STEP_DIV  = 25_000_000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [1:0]                   dir_i,
  input  logic                         dir_valid_i,
  input  logic [3:0]                   cell_x_i,
  input  logic [3:0]                   cell_y_i,
  output logic                         cell_body_o,
  output logic [3:0]                   head_x_o,
  output logic [3:0]                   head_y_o,
  output logic [3:0]                   apple_x_o,
  output logic [3:0]                   apple_y_o,
  output logic [$clog2(MAX_LEN+1)-1:0] length_o,
  output logic [7:0]                   score_o,
  output logic [1:0]                   state_o,
  output logic                         game_over_o
);

  localparam int unsigned LenW    = $clog2(MAX_LEN + 1);
  localparam int unsigned CntW    = $clog2(STEP_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

  function automatic logic [3:0] init_seg_x(input int unsigned i);
    return (i < START_LEN) ? 4'(InitHeadX - i) : 4'd0;
  endfunction

  function automatic logic [3:0] init_seg_y(input int unsigned i);
    return (i < START_LEN) ? InitHeadY : 4'd0;
  endfunction

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d, pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      seg_x_q [MAX_LEN];
  logic [3:0]      seg_y_q [MAX_LEN];
  logic [3:0]      seg_x_d [MAX_LEN];
  logic [3:0]      seg_y_d [MAX_LEN];
  logic [3:0]      apple_x_q, apple_y_q, apple_x_d, apple_y_d;
  logic [LenW-1:0] len_q, len_d;
  logic [7:0]      score_q, score_d;
  logic            game_over_q;
  logic [7:0]      lfsr;

  logic [3:0]         next_x, next_y;
  logic               wall_hit, eat, self_hit, cand_on_body;
  logic [MAX_LEN-1:0] in_body, in_body_no_tail, hit_next, hit_cand, hit_query;

  snake_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .value_o (lfsr)
  );

  // The step always uses the pending direction, so the next head follows it.
  always_comb begin
    next_x   = seg_x_q[0];
    next_y   = seg_y_q[0];
    wall_hit = 1'b0;
    unique case (pend_q)
      DirUp: begin
        wall_hit = (seg_y_q[0] == 4'd0);
        next_y   = seg_y_q[0] - 4'd1;
      end
      DirRight: begin
        wall_hit = (seg_x_q[0] == FieldMax);
        next_x   = seg_x_q[0] + 4'd1;
      end
      DirDown: begin
        wall_hit = (seg_y_q[0] == FieldMax);
        next_y   = seg_y_q[0] + 4'd1;
      end
      DirLeft: begin
        wall_hit = (seg_x_q[0] == 4'd0);
        next_x   = seg_x_q[0] - 4'd1;
      end
    endcase
  end

  assign eat = (next_x == apple_x_q) && (next_y == apple_y_q);

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
    assign in_body[g]         = LenW'(g) < len_q;
    assign in_body_no_tail[g] = LenW'(g + 1) < len_q;
    assign hit_next[g]  = (seg_x_q[g] == next_x) && (seg_y_q[g] == next_y);
    assign hit_cand[g]  = (seg_x_q[g] == lfsr[7:4]) && (seg_y_q[g] == lfsr[3:0]);
    assign hit_query[g] = (seg_x_q[g] == cell_x_i) && (seg_y_q[g] == cell_y_i);
  end

  // The tail vacates on a plain move but stays put when the snake grows.
  assign self_hit     = |(hit_next & (eat ? in_body : in_body_no_tail));
  assign cand_on_body = |(hit_cand & in_body);
  assign cell_body_o  = |(hit_query & in_body);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    len_d     = len_q;
    score_d   = score_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StRun;
      end
      StRun: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          dir_d = pend_q;
          if (wall_hit || self_hit) begin
            state_d = StOver;
          end else begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = next_x;
            seg_y_d[0] = next_y;
            if (eat) begin
              len_d   = len_q + 1'b1;
              score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              state_d = (len_d == LenW'(MAX_LEN)) ? StOver : StPlace;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPlace: begin
        if (!cand_on_body) begin
          apple_x_d = lfsr[7:4];
          apple_y_d = lfsr[3:0];
          state_d   = StRun;
        end
      end
      StOver: begin
        if (start_i) begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = init_seg_x(i);
            seg_y_d[i] = init_seg_y(i);
          end
          dir_d     = DirRight;
          pend_d    = DirRight;
          cnt_d     = '0;
          apple_x_d = InitAppleX;
          apple_y_d = InitAppleY;
          len_d     = LenW'(START_LEN);
          score_d   = '0;
          state_d   = StRun;
        end
      end
    endcase

    // Checked against dir_d so a request in the step cycle is judged against the new heading.
    if (dir_valid_i && (state_q == StRun || state_q == StPlace) &&
        !is_reverse(dir_e'(dir_i), dir_d)) begin
      pend_d = dir_e'(dir_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dir_q   <= DirRight;
      pend_q  <= DirRight;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_seg_x(i);
        seg_y_q[i] <= init_seg_y(i);
      end
      apple_x_q   <= InitAppleX;
      apple_y_q   <= InitAppleY;
      len_q       <= LenW'(START_LEN);
      score_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      apple_x_q   <= apple_x_d;
      apple_y_q   <= apple_y_d;
      len_q       <= len_d;
      score_q     <= score_d;
      game_over_q <= (state_d == StOver);
    end
  end

  assign head_x_o    = seg_x_q[0];
  assign head_y_o    = seg_y_q[0];
  assign apple_x_o   = apple_x_q;
  assign apple_y_o   = apple_y_q;
  assign length_o    = len_q;
  assign score_o     = score_q;
  assign state_o     = state_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench: four controller variants share stimulus; each scenario checks one of them.
module tb_snake_game_ctrl;

  localparam int unsigned StepDiv = 4;
  localparam logic [1:0] Up = 2'd0, Rt = 2'd1, Dn = 2'd2, Lt = 2'd3;
  localparam logic [1:0] SIdle = 2'd0, SRun = 2'd1, SPlace = 2'd2, SOver = 2'd3;

  logic       clk = 1'b0;
  logic       rst, start, dv;
  logic [1:0] dir;
  logic [3:0] cx, cy;

  // 0: main (16/3), 1: start length 4, 2: start length 5, 3: win (MAX_LEN 4)
  logic [3:0] hx [4];
  logic [3:0] hy [4];
  logic [3:0] ax [4];
  logic [3:0] ay [4];
  logic [7:0] sc [4];
  logic [1:0] st [4];
  logic       go [4];
  logic       body [4];
  logic [4:0] len0, len1, len2;
  logic [2:0] len3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snake_game_ctrl #(.MAX_LEN(16), .START_LEN(3), .STEP_DIV(StepDiv)) u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir), .dir_valid_i(dv),
    .cell_x_i(cx), .cell_y_i(cy), .cell_body_o(body[0]), .head_x_o(hx[0]), .head_y_o(hy[0]),
    .apple_x_o(ax[0]), .apple_y_o(ay[0]), .length_o(len0), .score_o(sc[0]), .state_o(st[0]),
    .game_over_o(go[0])
  );

  snake_game_ctrl #(.MAX_LEN(16), .START_LEN(4), .STEP_DIV(StepDiv)) u_len4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir), .dir_valid_i(dv),
    .cell_x_i(cx), .cell_y_i(cy), .cell_body_o(body[1]), .head_x_o(hx[1]), .head_y_o(hy[1]),
    .apple_x_o(ax[1]), .apple_y_o(ay[1]), .length_o(len1), .score_o(sc[1]), .state_o(st[1]),
    .game_over_o(go[1])
  );

  snake_game_ctrl #(.MAX_LEN(16), .START_LEN(5), .STEP_DIV(StepDiv)) u_len5 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir), .dir_valid_i(dv),
    .cell_x_i(cx), .cell_y_i(cy), .cell_body_o(body[2]), .head_x_o(hx[2]), .head_y_o(hy[2]),
    .apple_x_o(ax[2]), .apple_y_o(ay[2]), .length_o(len2), .score_o(sc[2]), .state_o(st[2]),
    .game_over_o(go[2])
  );

  snake_game_ctrl #(.MAX_LEN(4), .START_LEN(3), .STEP_DIV(StepDiv)) u_win (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir), .dir_valid_i(dv),
    .cell_x_i(cx), .cell_y_i(cy), .cell_body_o(body[3]), .head_x_o(hx[3]), .head_y_o(hy[3]),
    .apple_x_o(ax[3]), .apple_y_o(ay[3]), .length_o(len3), .score_o(sc[3]), .state_o(st[3]),
    .game_over_o(go[3])
  );

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [4:0] len_of(input int i);
    case (i)
      0:       return len0;
      1:       return len1;
      2:       return len2;
      default: return {2'b00, len3};
    endcase
  endfunction

  typedef struct {
    bit         restart;
    bit         dv0;
    logic [1:0] d0;
    bit         dv1;
    logic [1:0] d1;
    int         inst;
    logic [3:0] hx;
    logic [3:0] hy;
    logic [4:0] len;
    logic [7:0] score;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       b;
  } query_t;

  vec_t   vecs [25];
  query_t qv [8];

  function automatic vec_t mk(input bit rs, input bit v0, input logic [1:0] d0, input bit v1,
                              input logic [1:0] d1, input int inst, input int x, input int y,
                              input int l, input int s, input logic [1:0] est);
    vec_t v;
    v.restart = rs;
    v.dv0 = v0;
    v.d0 = d0;
    v.dv1 = v1;
    v.d1 = d1;
    v.inst = inst;
    v.hx = 4'(x);
    v.hy = 4'(y);
    v.len = 5'(l);
    v.score = 8'(s);
    v.st = est;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_inst(input int i, input string tag, input logic [3:0] ehx,
                            input logic [3:0] ehy, input logic [4:0] elen, input logic [7:0] esc,
                            input logic [1:0] est);
    check({tag, ".head_x"}, 32'(hx[i]), 32'(ehx));
    check({tag, ".head_y"}, 32'(hy[i]), 32'(ehy));
    check({tag, ".length"}, 32'(len_of(i)), 32'(elen));
    check({tag, ".score"}, 32'(sc[i]), 32'(esc));
    check({tag, ".state"}, 32'(st[i]), 32'(est));
  endtask

  task automatic do_restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One entry = one move period: requests in counter cycles 0 and 1, check after the step edge.
  task automatic run_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      if (vecs[k].restart) do_restart();
      dv = vecs[k].dv0;
      dir = vecs[k].d0;
      tick();
      dv = vecs[k].dv1;
      dir = vecs[k].d1;
      tick();
      dv = 1'b0;
      tick();
      tick();
      check_inst(vecs[k].inst, $sformatf("vec%0d", k), vecs[k].hx, vecs[k].hy, vecs[k].len,
                 vecs[k].score, vecs[k].st);
    end
  endtask

  function automatic bit on_eaten_body(input logic [7:0] c);
    return (c[3:0] == 4'd8) && (c[7:4] >= 4'd9) && (c[7:4] <= 4'd12);
  endfunction

  initial begin
    logic [7:0] cand;
    int         n;

    // Reverse rejection and turns on the main snake
    vecs[0]  = mk(1, 1, Lt, 0, Up, 0,  9, 8, 3, 0, SRun);
    vecs[1]  = mk(0, 1, Up, 1, Rt, 0, 10, 8, 3, 0, SRun);
    vecs[2]  = mk(0, 1, Dn, 0, Up, 0, 10, 9, 3, 0, SRun);
    vecs[3]  = mk(0, 1, Rt, 0, Up, 0, 11, 9, 3, 0, SRun);
    vecs[4]  = mk(0, 0, Up, 0, Up, 0, 12, 9, 3, 0, SRun);
    // Self collision, length 5: up, left, down
    vecs[5]  = mk(1, 1, Up, 0, Up, 2,  8, 7, 5, 0, SRun);
    vecs[6]  = mk(0, 1, Lt, 0, Up, 2,  7, 7, 5, 0, SRun);
    vecs[7]  = mk(0, 1, Dn, 0, Up, 2,  7, 7, 5, 0, SOver);
    // Tail chase, length 4: entering the vacating tail is legal
    vecs[8]  = mk(1, 1, Up, 0, Up, 1,  8, 7, 4, 0, SRun);
    vecs[9]  = mk(0, 1, Lt, 0, Up, 1,  7, 7, 4, 0, SRun);
    vecs[10] = mk(0, 1, Dn, 0, Up, 1,  7, 8, 4, 0, SRun);
    vecs[11] = mk(0, 1, Rt, 0, Up, 1,  8, 8, 4, 0, SRun);
    // Wall at the right edge along y=7
    vecs[12] = mk(1, 1, Up, 0, Up, 0,  8, 7, 3, 0, SRun);
    vecs[13] = mk(0, 1, Rt, 0, Up, 0,  9, 7, 3, 0, SRun);
    for (int k = 0; k < 6; k++) vecs[14+k] = mk(0, 0, Up, 0, Up, 0, 10 + k, 7, 3, 0, SRun);
    vecs[20] = mk(0, 0, Up, 0, Up, 0, 15, 7, 3, 0, SOver);
    // Win at MAX_LEN 4 on the first apple
    vecs[21] = mk(1, 0, Up, 0, Up, 3,  9, 8, 3, 0, SRun);
    vecs[22] = mk(0, 0, Up, 0, Up, 3, 10, 8, 3, 0, SRun);
    vecs[23] = mk(0, 0, Up, 0, Up, 3, 11, 8, 3, 0, SRun);
    vecs[24] = mk(0, 0, Up, 0, Up, 3, 12, 8, 4, 1, SOver);

    qv[0] = '{4'd8,  4'd8, 1'b1};
    qv[1] = '{4'd7,  4'd8, 1'b1};
    qv[2] = '{4'd6,  4'd8, 1'b1};
    qv[3] = '{4'd5,  4'd8, 1'b0};
    qv[4] = '{4'd9,  4'd8, 1'b0};
    qv[5] = '{4'd0,  4'd0, 1'b0};
    qv[6] = '{4'd8,  4'd7, 1'b0};
    qv[7] = '{4'd12, 4'd8, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    dv = 1'b0;
    dir = 2'd0;
    cx = 4'd0;
    cy = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    check_inst(0, "reset", 4'd8, 4'd8, 5'd3, 8'd0, SIdle);
    check("reset.apple_x", 32'(ax[0]), 32'd12);
    check("reset.apple_y", 32'(ay[0]), 32'd8);
    check("reset.game_over", 32'(go[0]), 32'd0);
    repeat (10) tick();
    check_inst(0, "idle_hold", 4'd8, 4'd8, 5'd3, 8'd0, SIdle);

    foreach (qv[k]) begin
      cx = qv[k].x;
      cy = qv[k].y;
      #1;
      check($sformatf("query%0d", k), 32'(body[0]), 32'(qv[k].b));
    end
    tick();

    run_vecs(0, 20);

    // Frozen in OVER, then restart re-initialises and the counter starts over
    check("wall.game_over", 32'(go[0]), 32'd1);
    repeat (3) tick();
    check_inst(0, "over_hold", 4'd15, 4'd7, 5'd3, 8'd0, SOver);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_inst(0, "restart", 4'd8, 4'd8, 5'd3, 8'd0, SRun);
    check("restart.apple_x", 32'(ax[0]), 32'd12);
    check("restart.game_over", 32'(go[0]), 32'd0);
    repeat (4) tick();
    check_inst(0, "restart_step", 4'd9, 4'd8, 5'd3, 8'd0, SRun);

    run_vecs(21, 24);

    // Main snake ate the apple on the same step: PLACE, then the first free LFSR cell
    check_inst(0, "eat", 4'd12, 4'd8, 5'd4, 8'd1, SPlace);
    check("eat.game_over", 32'(go[0]), 32'd0);
    cand = m_lfsr;
    n = 0;
    while (on_eaten_body(cand) && n < 300) begin
      cand = lfsr_step(cand);
      n++;
    end
    repeat (n + 1) tick();
    check("place.state", 32'(st[0]), 32'(SRun));
    check("place.apple_x", 32'(ax[0]), 32'(cand[7:4]));
    check("place.apple_y", 32'(ay[0]), 32'(cand[3:0]));

    // Full-field occupancy of the frozen winning snake: (9..12, 8)
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        cx = 4'(x);
        cy = 4'(y);
        #1;
        check($sformatf("grid(%0d,%0d)", x, y), 32'(body[3]),
              32'((y == 8) && (x >= 9) && (x <= 12)));
      end
    end
    check_inst(3, "win_hold", 4'd12, 4'd8, 5'd4, 8'd1, SOver);
    check("win.game_over", 32'(go[3]), 32'd1);
    tick();

    // Reset while placing the apple
    do_restart();
    repeat (16) tick();
    check_inst(0, "eat2", 4'd12, 4'd8, 5'd4, 8'd1, SPlace);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_inst(0, "rst_in_place", 4'd8, 4'd8, 5'd3, 8'd0, SIdle);
    check("rst_in_place.apple_x", 32'(ax[0]), 32'd12);
    check("rst_in_place.apple_y", 32'(ay[0]), 32'd8);
    check("rst_in_place.game_over", 32'(go[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-state controller for the snake field renderer. It owns the snake body, the apple position, score and game phase, and advances the game one step per move period. It answers per-cell occupancy queries so the field renderer can colour each pixel. It sits between the button/direction decoder and the renderer, on the pixel clock domain.

## Interface
Parameters:
- MAX_LEN, 16: maximum snake length in segments; reaching it ends the game (win).
- START_LEN, 3: length after reset/restart; 2 ≤ START_LEN < MAX_LEN.
- STEP_DIV, 25_000_000: clock cycles per move step; ≥ 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start from IDLE / restart from OVER (level, sampled per cycle).
- dir_i  in  2  requested direction: 0 up, 1 right, 2 down, 3 left.
- dir_valid_i  in  1  dir_i qualifier.
- cell_x_i, cell_y_i  in  4 each  queried field cell (16×16 field).
- cell_body_o  out  1  queried cell holds a body segment (index < length).
- head_x_o, head_y_o  out  4 each  head cell (segment 0).
- apple_x_o, apple_y_o  out  4 each  apple cell.
- length_o  out  $clog2(MAX_LEN+1)  current length.
- score_o  out  8  apples eaten, saturating at 255.
- state_o  out  2  0 IDLE, 1 RUN, 2 PLACE, 3 OVER.
- game_over_o  out  1  state_o == OVER.

## Operation
- Body: register array seg[0..MAX_LEN-1] of {x,y}; seg[0] = head. Step shifts seg[i] ← seg[i-1], seg[0] ← next head.
- Reset/restart init: seg[i] = (8−i, 8) for i < START_LEN, others (0,0); dir = right; apple = (12,8); score 0; tick counter 0.
- Direction: a dir_valid_i pulse writes pending_dir unless it is the 180° reverse of the current dir (ignored). pending_dir becomes dir at each step. The last valid request before the step wins.
- States:
  - IDLE: frozen; start_i → RUN.
  - RUN: tick counter counts 0..STEP_DIV−1. At STEP_DIV−1 a step occurs and the counter returns to 0.
  - Step evaluation, in priority order:
    1. Wall: moving off the field edge (coordinate would wrap) → OVER; body unchanged.
    2. Self: next head equals seg[i] for i < length−1 → OVER. The tail is excluded because it vacates, unless the snake is eating this step, in which case i < length is checked.
    3. Eat: next head == apple → shift, length+1, score+1. If the new length == MAX_LEN → OVER, otherwise → PLACE.
    4. Otherwise shift only → RUN.
  - PLACE: each cycle, candidate = LFSR value {x = lfsr[7:4], y = lfsr[3:0]}. The first candidate not on the body is written to the apple registers → RUN. The tick counter is held during PLACE.
  - OVER: frozen, outputs held; start_i → re-init → RUN.
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset only. It advances every cycle in every state. Cell (0,0) is never generated.
- cell_body_o: combinational OR of the matches against seg[i], i < length_o.

## Timing
- All outputs registered except cell_body_o (0-cycle combinational query).
- Reset values: state IDLE, head (8,8), apple (12,8), length START_LEN, score 0, game_over 0.
- Step outputs (head, length, score, state) update on the edge following the cycle where counter == STEP_DIV−1.
- The first step occurs STEP_DIV cycles after entering RUN.
- dir_valid_i in the step cycle itself is too late for that step; it applies to the next step.
- PLACE lasts ≥ 1 cycle. The apple updates on exit.
- rst_i mid-step or mid-PLACE overrides everything: full init state on the next edge.
- start_i in RUN/PLACE is ignored.

## Structure
- Shared defines/package: direction codes, state encodings, field size (16), init head/apple coordinates, LFSR seed.
- Sub-module: snake_lfsr (8-bit Galois/Fibonacci LFSR, enable always 1, sync reset to seed).
- Collision/occupancy comparators: generate loop over MAX_LEN in the top module.

## Test plan
(Use STEP_DIV=4 for all scenarios.)
- Reset, then start_i: after 4 cycles head (9,8), length 3, state RUN. After 3 more steps head (12,8) eats the apple → length 4, score 1, PLACE, then apple ≠ any body cell, RUN.
- Reverse rejection: running right, dir_valid_i with left → next step head x+1, y unchanged. Up then right within one period → right applied.
- Wall: head (15,y) moving right → state OVER, head unchanged, game_over_o 1. start_i → re-init, RUN.
- Self-collision: length 5 snake, turn sequence up, left, down into its own body → OVER on the colliding step. Tail-chasing into the vacating tail cell does not collide.
- Win: MAX_LEN=4, START_LEN=3, eat one apple → length 4, OVER, no PLACE.
- Query: for every cell, compare cell_body_o against the bench model. Assert rst_i during PLACE → IDLE with init values on the next edge.
